// File: rtl/cpu_irq_pkg.sv
// Shared constants for the interrupt path: register map, decoder PC-select
// codes and the interrupt sequencer state encoding.
package cpu_irq_pkg;

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_CAUSE   = 2'd2;
    localparam logic [1:0] ADDR_CTRL    = 2'd3;

    // Decoder PC-select codes that mean "entering the kernel".
    localparam logic [2:0] PCSRC_IRQ  = 3'b100;
    localparam logic [2:0] PCSRC_XADR = 3'b101;

    localparam int CAUSE_EXC_BIT = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder: index 0 is the most urgent source.
module irq_prio_enc #(
    parameter int NSRC = 4,
    parameter int ID_W = 3
) (
    input  logic [NSRC-1:0] req_i,
    output logic            valid_o,
    output logic [ID_W-1:0] id_o
);

    always_comb begin
        valid_o = |req_i;
        id_o    = '0;
        // Scan downwards so the lowest set index is the last assignment.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                id_o = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt sequencer for the single-cycle MIPS core: edge-captured pending
// bits, enable mask, and the take/service/return handshake with the decoder.
module irq_controller
    import cpu_irq_pkg::*;
#(
    parameter int NSRC = 4,
    parameter int ID_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    input  logic            supervisor,
    input  logic [2:0]      pc_src,
    input  logic            bus_wr,
    input  logic [1:0]      bus_addr,
    input  logic [31:0]     bus_wdata,
    output logic [31:0]     bus_rdata,
    output logic            IRQ,
    output logic [1:0]      dbg_state
);

    irq_state_e      state_q, state_d;
    logic [NSRC-1:0] src_q;
    logic [NSRC-1:0] enable_q;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [ID_W-1:0] cause_id_q;
    logic            cause_exc_q;
    logic            gie_q;
    logic            prev_sup_q;

    logic [NSRC-1:0] src_rise;
    logic            win_valid;
    logic [ID_W-1:0] win_id;
    logic            req;
    logic            take;
    logic            exc_entry;
    logic            wr_enable, wr_pending, wr_ctrl;
    logic            unused_wdata;

    assign src_rise   = irq_src & ~src_q;
    assign wr_enable  = bus_wr && (bus_addr == ADDR_ENABLE);
    assign wr_pending = bus_wr && (bus_addr == ADDR_PENDING);
    assign wr_ctrl    = bus_wr && (bus_addr == ADDR_CTRL);
    assign unused_wdata = ^bus_wdata[31:NSRC];

    irq_prio_enc #(
        .NSRC (NSRC),
        .ID_W (ID_W)
    ) u_prio (
        .req_i   (pending_q & enable_q),
        .valid_o (win_valid),
        .id_o    (win_id)
    );

    assign req = gie_q & win_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // An exception always outranks a pending take; entering the kernel by any
    // other path while requesting parks us in SERVICE without consuming a source.
    always_comb begin
        state_d   = state_q;
        take      = 1'b0;
        exc_entry = 1'b0;
        case (state_q)
            IDLE: begin
                if (!supervisor) begin
                    if (pc_src == PCSRC_XADR) begin
                        state_d   = SERVICE;
                        exc_entry = 1'b1;
                    end else if (req) begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (supervisor) begin
                    state_d = SERVICE;
                end else if (pc_src == PCSRC_XADR) begin
                    state_d   = SERVICE;
                    exc_entry = 1'b1;
                end else if (pc_src == PCSRC_IRQ) begin
                    state_d = SERVICE;
                    take    = 1'b1;
                end else if (!req) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (prev_sup_q && !supervisor) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clears first, then new edges, so a same-cycle rising edge always survives.
    always_comb begin
        pending_d = pending_q;
        if (wr_pending) begin
            pending_d = pending_d & ~bus_wdata[NSRC-1:0];
        end
        for (int i = 0; i < NSRC; i++) begin
            if (take && win_valid && (win_id == ID_W'(i))) begin
                pending_d[i] = 1'b0;
            end
        end
        pending_d = pending_d | src_rise;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q       <= '0;
            enable_q    <= '0;
            pending_q   <= '0;
            cause_id_q  <= '0;
            cause_exc_q <= 1'b0;
            gie_q       <= 1'b0;
            prev_sup_q  <= 1'b0;
        end else begin
            src_q      <= irq_src;
            prev_sup_q <= supervisor;
            pending_q  <= pending_d;
            if (wr_enable) begin
                enable_q <= bus_wdata[NSRC-1:0];
            end
            if (wr_ctrl) begin
                gie_q <= bus_wdata[0];
            end
            if (take) begin
                cause_exc_q <= 1'b0;
                if (win_valid) begin
                    cause_id_q <= win_id;
                end
            end
            if (exc_entry) begin
                cause_exc_q <= 1'b1;
            end
        end
    end

    always_comb begin
        bus_rdata = '0;
        case (bus_addr)
            ADDR_ENABLE:  bus_rdata[NSRC-1:0] = enable_q;
            ADDR_PENDING: bus_rdata[NSRC-1:0] = pending_q;
            ADDR_CAUSE: begin
                bus_rdata[ID_W-1:0]      = cause_id_q;
                bus_rdata[CAUSE_EXC_BIT] = cause_exc_q;
            end
            ADDR_CTRL:    bus_rdata[0] = gie_q;
            default:      bus_rdata = '0;
        endcase
    end

    assign IRQ       = (state_q == REQ);
    assign dbg_state = state_q;

endmodule
